// File: rtl/dct2_pkg.sv
// Shared types and the DCT-II stage-packed to natural-order index rule.
package dct2_pkg;

  localparam int LOG2_NMAX_DEF = 6;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  // Stage-packed element feeding coefficient k of an N=2^log2n transform.
  function automatic logic [6:0] src_index(
    input logic [6:0] k,
    input logic [2:0] log2n
  );
    logic [6:0] n;
    logic [2:0] t;
    logic [6:0] idx;
    n = 7'd1 << log2n;
    t = 3'd0;
    for (int b = 5; b >= 0; b--) begin
      if (k[b]) t = 3'(b);
    end
    if (k == 7'd0) begin
      idx = 7'd0;
    end else if (k == (n >> 1)) begin
      idx = 7'd1;
    end else begin
      idx = (n >> (t + 3'd1)) + (k >> (t + 3'd1));
    end
    return idx;
  endfunction

endpackage

// File: rtl/dct2_coef_perm.sv
// Combinational reorder of a stage-packed butterfly vector into natural order.
module dct2_coef_perm
  import dct2_pkg::*;
#(
  parameter int W = 16,
  parameter int LOG2_NMAX = LOG2_NMAX_DEF,
  localparam int NMAX = 1 << LOG2_NMAX
) (
  input  logic [2:0]        log2n,
  input  logic [NMAX*W-1:0] stage_i,
  output logic [NMAX*W-1:0] nat_o
);

  logic [6:0] n;

  always_comb begin
    nat_o = '0;
    n = 7'd1 << log2n;
    for (int k = 0; k < NMAX; k++) begin
      if (7'(k) < n) begin
        nat_o[W*k +: W] =
          stage_i[W*int'(src_index(7'(k), log2n)) +: W];
      end
    end
  end

endmodule

// File: rtl/dct2_coef_reorder_stream.sv
// Captures a reordered DCT-II result vector and streams it LANES per beat.
module dct2_coef_reorder_stream
  import dct2_pkg::*;
#(
  parameter int W = 16,
  parameter int LOG2_NMAX = LOG2_NMAX_DEF,
  parameter int LANES = 8,
  localparam int NMAX = 1 << LOG2_NMAX,
  localparam int LOG2_LANES = $clog2(LANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_log2n,
  input  logic [NMAX*W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_data,
  output logic [LOG2_NMAX-1:0] out_beat,
  output logic                 out_last,
  output logic [2:0]           out_log2n
);

  state_e                 state_q, state_d;
  logic [LOG2_NMAX-1:0]   beat_q, beat_d;
  logic [2:0]             log2n_q, log2n_d;
  logic [NMAX*W-1:0]      buf_q, buf_d;
  logic [NMAX*W-1:0]      perm_data;
  logic [2:0]             log2n_cl;
  logic [LOG2_NMAX-1:0]   last_beat;
  logic                   fire;
  logic                   load;

  always_comb begin
    if (in_log2n < 3'd2) begin
      log2n_cl = 3'd2;
    end else if (in_log2n > 3'(LOG2_NMAX)) begin
      log2n_cl = 3'(LOG2_NMAX);
    end else begin
      log2n_cl = in_log2n;
    end
  end

  dct2_coef_perm #(
    .W         (W),
    .LOG2_NMAX (LOG2_NMAX)
  ) u_perm (
    .log2n   (log2n_cl),
    .stage_i (in_data),
    .nat_o   (perm_data)
  );

  // Vectors no wider than a beat still take one beat.
  always_comb begin
    last_beat = '0;
    if (log2n_q > 3'(LOG2_LANES)) begin
      last_beat = LOG2_NMAX'(
        (32'd1 << (log2n_q - 3'(LOG2_LANES))) - 32'd1);
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && (beat_q == last_beat);
  assign out_beat  = beat_q;
  assign out_log2n = log2n_q;
  assign out_data  = buf_q[W*LANES*int'(beat_q) +: W*LANES];
  assign fire      = out_valid && out_ready;
  assign in_ready  = rst_n
                  && ((state_q == IDLE) || (fire && out_last));
  assign load      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    log2n_d = log2n_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: ;
      SEND: begin
        if (fire) begin
          if (out_last) state_d = IDLE;
          else beat_d = beat_q + LOG2_NMAX'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      buf_d   = perm_data;
      log2n_d = log2n_cl;
      beat_d  = '0;
      state_d = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      log2n_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      log2n_q <= log2n_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_dct2_coef_reorder_stream.sv
// Randomized bench for dct2_coef_reorder_stream against a scatter-form model.
module tb_dct2_coef_reorder_stream;

  localparam int W = 16;
  localparam int LOG2_NMAX = 6;
  localparam int LANES = 8;
  localparam int NMAX = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_log2n;
  logic [NMAX*W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_data;
  logic [LOG2_NMAX-1:0] out_beat;
  logic                 out_last;
  logic [2:0]           out_log2n;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_c [NMAX];
  logic [W-1:0] got [NMAX];
  int exp_lg;

  int ord32 [32] = '{0, 16, 8, 17, 4, 18, 9, 19, 2, 20, 10, 21,
                     5, 22, 11, 23, 1, 24, 12, 25, 6, 26, 13, 27,
                     3, 28, 14, 29, 7, 30, 15, 31};

  dct2_coef_reorder_stream #(
    .W(W), .LOG2_NMAX(LOG2_NMAX), .LANES(LANES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_log2n(in_log2n), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beat(out_beat),
    .out_last(out_last), .out_log2n(out_log2n)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Model: each odd group of c entries scatters to k = (2j+1) << t.
  task automatic build_exp(input logic [NMAX*W-1:0] din,
                           input int lg_raw);
    int lg, n, c;
    lg = (lg_raw < 2) ? 2 : ((lg_raw > LOG2_NMAX) ? LOG2_NMAX : lg_raw);
    n = 1 << lg;
    exp_lg = lg;
    for (int k = 0; k < NMAX; k++) exp_c[k] = '0;
    exp_c[0] = din[0 +: W];
    exp_c[n/2] = din[W +: W];
    for (int t = 0; t <= lg - 2; t++) begin
      c = n >> (t + 1);
      for (int j = 0; j < c; j++)
        exp_c[(2*j+1) << t] = din[W*(c+j) +: W];
    end
  endtask

  function automatic logic [NMAX*W-1:0] rand_vec();
    logic [NMAX*W-1:0] v;
    for (int i = 0; i < NMAX; i++) v[W*i +: W] = W'($urandom);
    return v;
  endfunction

  function automatic int count_bad(input int upto, output int first);
    int bad = 0;
    first = -1;
    for (int k = 0; k < upto; k++) begin
      if (got[k] !== exp_c[k]) begin
        if (first < 0) first = k;
        bad++;
      end
    end
    return bad;
  endfunction

  function automatic int exp_beats(input int lg);
    return ((1 << lg) <= LANES) ? 1 : ((1 << lg) / LANES);
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [NMAX*W-1:0] din, input int lg_raw,
                      output bit acc);
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = din;
    in_log2n = 3'(lg_raw);
    for (int c = 0; c < 40; c++) begin
      if (in_ready === 1'b1) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input bit rnd, output int nb, output int berr,
                      output bit to, output logic [2:0] lg_seen);
    int c = 0;
    bit done = 1'b0;
    nb = 0;
    berr = 0;
    lg_seen = 'x;
    for (int k = 0; k < NMAX; k++) got[k] = 'x;
    while (!done && c < 400) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        if (out_beat !== LOG2_NMAX'(nb)) berr++;
        if (nb == 0) lg_seen = out_log2n;
        for (int l = 0; l < LANES; l++)
          if (nb*LANES + l < NMAX) got[nb*LANES + l] = out_data[W*l +: W];
        nb++;
        if (out_last) done = 1'b1;
      end
      @(negedge clk);
      c++;
    end
    out_ready = 1'b1;
    to = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_last !== 1'b0) begin
      failures++; $display("FAIL reset_out_last got=%b want=0", out_last);
    end
    checks++;
    if (out_beat !== '0 || out_log2n !== 3'd0) begin
      failures++;
      $display("FAIL reset_beat_log2n got=%0d/%0d want=0/0",
               out_beat, out_log2n);
    end
    checks++;
    if (out_data !== '0) begin
      failures++; $display("FAIL reset_out_data got=%h want=0", out_data);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL release_in_ready got=%b want=1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_n4();
    logic [NMAX*W-1:0] din;
    logic [W-1:0] want [LANES];
    bit acc;
    want = '{16'd100, 16'd102, 16'd101, 16'd103, 16'd0, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < NMAX; i++) din[W*i +: W] = W'(100 + i);
    send(din, 2, acc);
    checks++;
    if (out_valid !== 1'b1 || out_beat !== '0) begin
      failures++;
      $display("FAIL n4_latency got valid=%b beat=%0d want 1/0",
               out_valid, out_beat);
    end
    for (int l = 0; l < LANES; l++) begin
      checks++;
      if (out_data[W*l +: W] !== want[l]) begin
        failures++;
        $display("FAIL n4_lane%0d got=%0d want=%0d", l,
                 out_data[W*l +: W], want[l]);
      end
    end
    checks++;
    if (out_last !== 1'b1 || out_log2n !== 3'd2) begin
      failures++;
      $display("FAIL n4_last_log2n got=%b/%0d want=1/2", out_last, out_log2n);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL n4_idle got=%b want=0", out_valid);
    end
  endtask

  task automatic test_n32_order();
    logic [NMAX*W-1:0] din;
    int nb, berr, bad;
    bit acc, to;
    logic [2:0] lgs;
    for (int i = 0; i < NMAX; i++) din[W*i +: W] = W'(i);
    send(din, 5, acc);
    recv(1'b0, nb, berr, to, lgs);
    checks++;
    if (to || nb != 4 || berr != 0) begin
      failures++;
      $display("FAIL n32_beats got=%0d berr=%0d to=%0d want=4", nb, berr, to);
    end
    bad = 0;
    for (int k = 0; k < 32; k++)
      if (got[k] !== W'(ord32[k])) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL n32_order got %0d bad lanes want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [NMAX*W-1:0] a, b;
    int nb, berr, bad, first;
    bit acc, to;
    logic [2:0] lgs;
    int b0 [8] = '{0, 32, 16, 33, 8, 34, 17, 35};
    for (int i = 0; i < NMAX; i++) a[W*i +: W] = W'(i);
    b = rand_vec();
    build_exp(a, 6);
    send(a, 6, acc);
    for (int bt = 0; bt < 8; bt++) begin
      checks++;
      if (out_valid !== 1'b1 || out_beat !== LOG2_NMAX'(bt)
          || out_last !== (bt == 7)) begin
        failures++;
        $display("FAIL b2b_beat%0d got v=%b beat=%0d last=%b", bt,
                 out_valid, out_beat, out_last);
      end
      for (int l = 0; l < LANES; l++) got[bt*LANES + l] = out_data[W*l +: W];
      if (bt == 7) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++; $display("FAIL b2b_in_ready got=%b want=1", in_ready);
        end
        in_valid = 1'b1;
        in_data = b;
        in_log2n = 3'd6;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_beat !== '0) begin
      failures++;
      $display("FAIL b2b_bubble got v=%b beat=%0d want 1/0", out_valid, out_beat);
    end
    bad = 0;
    for (int l = 0; l < 8; l++) if (got[l] !== W'(b0[l])) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL b2b_beat0_const got %0d bad want 0", bad);
    end
    bad = count_bad(NMAX, first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_vecA got %0d bad (first k=%0d) want 0", bad, first);
    end
    build_exp(b, 6);
    recv(1'b0, nb, berr, to, lgs);
    bad = count_bad(NMAX, first);
    checks++;
    if (to || nb != 8 || berr != 0 || bad != 0) begin
      failures++;
      $display("FAIL b2b_vecB got nb=%0d berr=%0d bad=%0d to=%0d want 8/0/0/0",
               nb, berr, bad, to);
    end
  endtask

  task automatic test_backpressure();
    logic [NMAX*W-1:0] din;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int hs, bad;
    bit acc;
    din = rand_vec();
    build_exp(din, 4);
    send(din, 4, acc);
    hs = 0;
    for (int i = 0; i < 4; i++) begin
      out_ready = pat[i];
      bad = 0;
      for (int l = 0; l < LANES; l++)
        if (out_data[W*l +: W] !== exp_c[hs*LANES + l]) bad++;
      checks++;
      if (out_valid !== 1'b1 || out_beat !== LOG2_NMAX'(hs) || bad != 0) begin
        failures++;
        $display("FAIL bp_cycle%0d got v=%b beat=%0d bad=%0d want beat=%0d",
                 i, out_valid, out_beat, bad, hs);
      end
      if (out_valid === 1'b1 && out_ready) hs++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (hs != 2 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_count got hs=%0d v=%b want 2/0", hs, out_valid);
    end
  endtask

  task automatic test_clamp();
    int lgs_raw [2] = '{0, 7};
    logic [NMAX*W-1:0] din;
    int nb, berr, bad, first;
    bit acc, to;
    logic [2:0] lgs;
    for (int v = 0; v < 2; v++) begin
      din = rand_vec();
      build_exp(din, lgs_raw[v]);
      send(din, lgs_raw[v], acc);
      recv(1'b0, nb, berr, to, lgs);
      bad = count_bad(NMAX, first);
      checks++;
      if (to || lgs !== 3'(exp_lg) || nb != exp_beats(exp_lg)
          || berr != 0 || bad != 0) begin
        failures++;
        $display("FAIL clamp_%0d got lg=%0d nb=%0d bad=%0d want lg=%0d nb=%0d",
                 lgs_raw[v], lgs, nb, bad, exp_lg, exp_beats(exp_lg));
      end
    end
  endtask

  task automatic test_random();
    logic [NMAX*W-1:0] din;
    int lg, nb, berr, bad, first, upto;
    bit acc, to;
    logic [2:0] lgs;
    for (int v = 0; v < 12; v++) begin
      din = rand_vec();
      lg = $urandom_range(0, 7);
      build_exp(din, lg);
      send(din, lg, acc);
      recv(1'b1, nb, berr, to, lgs);
      upto = ((1 << exp_lg) > LANES) ? (1 << exp_lg) : LANES;
      bad = count_bad(upto, first);
      checks++;
      if (!acc || to || lgs !== 3'(exp_lg) || nb != exp_beats(exp_lg)
          || berr != 0 || bad != 0) begin
        failures++;
        $display("FAIL rand%0d lg=%0d got nb=%0d berr=%0d bad=%0d k=%0d",
                 v, lg, nb, berr, bad, first);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [NMAX*W-1:0] din;
    int nb, berr, bad, first;
    bit acc, to;
    logic [2:0] lgs;
    din = rand_vec();
    send(din, 6, acc);
    repeat (3) @(negedge clk);
    checks++;
    if (out_beat !== LOG2_NMAX'(3)) begin
      failures++; $display("FAIL mr_beat3 got=%0d want=3", out_beat);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL mr_in_ready_rst got=%b want=0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL mr_out_valid got=%b want=0", out_valid);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL mr_in_ready got=%b want=1", in_ready);
    end
    @(negedge clk);
    din = rand_vec();
    build_exp(din, 3);
    send(din, 3, acc);
    recv(1'b0, nb, berr, to, lgs);
    bad = count_bad(LANES, first);
    checks++;
    if (to || nb != 1 || berr != 0 || bad != 0) begin
      failures++;
      $display("FAIL mr_next got nb=%0d berr=%0d bad=%0d want 1/0/0",
               nb, berr, bad);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_log2n = 3'd0;
    in_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_n4();
    test_n32_order();
    test_back_to_back();
    test_backpressure();
    test_clamp();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
